alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameters: OPCODE_WIDTH, default 2, opcode MSB index (opcode is OPCODE_WIDTH+1 bits); DATA_WIDTH, default 3, operand MSB index (operands are DATA_WIDTH+1 bits); FIFO_DEPTH, default 4, command slots (power of 2).
REQ-002 SHALL have clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  command offered.
REQ-005 SHALL have in_ready  output  1  command slot free.
REQ-006 SHALL have in_opcode  input  OPCODE_WIDTH+1  command opcode.
REQ-007 SHALL have in_op1 and in_op2  input  DATA_WIDTH+1 each  command operands.
REQ-008 SHALL have alu_opcode, alu_op1, alu_op2  output  same widths  registered drive to the downstream ALU.
REQ-009 SHALL have alu_result  input  DATA_WIDTH+1, plus alu_carry and alu_zero  input  1 each; these are the ALU registered outputs.
REQ-010 SHALL have out_valid  output  1  result held.
REQ-011 SHALL have out_ready  input  1  consumer accepts.
REQ-012 SHALL have out_result  output  DATA_WIDTH+1, out_carry  output  1, out_zero  output  1, and out_opcode  output  OPCODE_WIDTH+1 (echo of the issued opcode).
REQ-013 SHALL have count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, and busy  output  1  (state != IDLE).

Function
REQ-014 SHALL queue commands in a FIFO_DEPTH-entry FIFO; a push occurs when in_valid && in_ready at a rising edge.
REQ-015 SHALL drive in_ready = (count < FIFO_DEPTH), combinational from registered count; a push offered while full SHALL be ignored.
REQ-016 SHALL wrap read and write pointers modulo FIFO_DEPTH; a push and pop on the same edge SHALL leave count unchanged.
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, OUTPUT.
REQ-018 IDLE: if count != 0, pop the head into alu_opcode/alu_op1/alu_op2 and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: hold ALU drive for one cycle so the ALU registers it, then go to CAPTURE unconditionally.
REQ-020 CAPTURE: latch alu_result/alu_carry/alu_zero into out_result/out_carry/out_zero, latch alu_opcode into out_opcode, set out_valid, and go to OUTPUT.
REQ-021 OUTPUT: hold all out_* stable while out_valid && !out_ready; on out_ready, clear out_valid and go to IDLE.
REQ-022 SHALL hold alu_* drive values between issues (no return to zero).
REQ-023 Latency: a command pushed at edge E0 into an empty, idle block SHALL be popped at E1 and captured at E3, with out_valid high after E3 (3 cycles).
REQ-024 Throughput: at most one command per 4 cycles with out_ready held high; pushes SHALL continue to be accepted during ISSUE, CAPTURE and OUTPUT.
REQ-025 Commands SHALL be issued and returned in strict FIFO order; none dropped or duplicated.
REQ-026 Opcodes SHALL pass through unmodified, including all values 0..7; the block SHALL NOT interpret them.

Reset
REQ-027 On rstn low, asynchronously: FIFO emptied (pointers and count = 0), state = IDLE, in_ready = 1, out_valid = 0, busy = 0, and all alu_* and out_* = 0.
REQ-028 Reset mid-operation SHALL discard queued and in-flight commands; no out_valid SHALL occur for them after release.
REQ-029 The first push SHALL be accepted on the first rising edge with rstn high.

Verification
REQ-030 Single ADD: push opcode 0, op1 10, op2 10 -> out_valid after 3 edges with out_result 4, out_carry 1, out_zero 0, out_opcode 0.
REQ-031 Fill: push 5 commands back-to-back with out_ready 0 -> 4 accepted while first issues, in_ready 0 at count 4, 5th held until a pop frees a slot.
REQ-032 Ordering: push ADD 1+1, SUB 3-3, XOR 5^5 with out_ready 1 -> results 2, 0 (zero 1), 0 (zero 1) in that order.
REQ-033 Backpressure: hold out_ready 0 for 10 cycles in OUTPUT -> out_* stable, no new issue, queued count unchanged by pops.
REQ-034 Reset mid-flight: assert rstn low during CAPTURE with 3 commands queued -> all outputs 0 and count 0 immediately, no out_valid after release.
REQ-035 Simultaneous push/pop at count 2 -> count stays 2 and pointers wrap correctly across 8 consecutive commands.

Source files
------------

// File: rtl/alu_cmd_seq_if.sv
// rtl/alu_cmd_seq_if.sv - command, ALU drive/return and result signals of alu_cmd_seq
interface alu_cmd_seq_if #(
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 3,
  parameter int FIFO_DEPTH   = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [OPCODE_WIDTH:0] in_opcode;
  logic [DATA_WIDTH:0]   in_op1;
  logic [DATA_WIDTH:0]   in_op2;

  logic [OPCODE_WIDTH:0] alu_opcode;
  logic [DATA_WIDTH:0]   alu_op1;
  logic [DATA_WIDTH:0]   alu_op2;
  logic [DATA_WIDTH:0]   alu_result;
  logic                  alu_carry;
  logic                  alu_zero;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   out_result;
  logic                  out_carry;
  logic                  out_zero;
  logic [OPCODE_WIDTH:0] out_opcode;

  logic [CNT_W-1:0]      count;
  logic                  busy;

  modport slave (
    input  in_valid, in_opcode, in_op1, in_op2,
    input  alu_result, alu_carry, alu_zero,
    input  out_ready,
    output in_ready,
    output alu_opcode, alu_op1, alu_op2,
    output out_valid, out_result, out_carry, out_zero, out_opcode,
    output count, busy
  );

  modport master (
    output in_valid, in_opcode, in_op1, in_op2,
    output alu_result, alu_carry, alu_zero,
    output out_ready,
    input  in_ready,
    input  alu_opcode, alu_op1, alu_op2,
    input  out_valid, out_result, out_carry, out_zero, out_opcode,
    input  count, busy
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - command FIFO feeding a registered ALU, one command in flight at a time
module alu_cmd_seq #(
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rstn,
  alu_cmd_seq_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = OPCODE_WIDTH + 2 * DATA_WIDTH + 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUTPUT} state_t;

  state_t                state_q;
  logic [CMD_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [OPCODE_WIDTH:0] alu_opcode_q, out_opcode_q;
  logic [DATA_WIDTH:0]   alu_op1_q, alu_op2_q, out_result_q;
  logic                  out_carry_q, out_zero_q, out_valid_q;
  logic                  push, pop;
  logic [CMD_W-1:0]      head;

  assign bus.in_ready = (count_q < DEPTH_C);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == IDLE) && (count_q != '0);
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_opcode, bus.in_op1, bus.in_op2};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_opcode_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            {alu_opcode_q, alu_op1_q, alu_op2_q} <= head;
            state_q <= ISSUE;
          end
        end
        // The ALU samples the drive on this edge; its result is ready by the next one.
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          out_result_q <= bus.alu_result;
          out_carry_q  <= bus.alu_carry;
          out_zero_q   <= bus.alu_zero;
          out_opcode_q <= alu_opcode_q;
          out_valid_q  <= 1'b1;
          state_q      <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_opcode = out_opcode_q;
  assign bus.count      = count_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - randomized bench for alu_cmd_seq against a queue-based reference
module tb_alu_cmd_seq;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       z;
  } res_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_seq_if bus ();
  alu_cmd_seq u_dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference ALU behaviour, shared by the stand-in ALU and the model.
  function automatic res_t alu_fn(input cmd_t c);
    logic [4:0] w;
    res_t       r;
    case (c.op)
      3'd0:    w = {1'b0, c.a} + {1'b0, c.b};
      3'd1:    w = {1'b0, c.a} - {1'b0, c.b};
      3'd2:    w = {1'b0, c.a ^ c.b};
      3'd3:    w = {1'b0, c.a & c.b};
      3'd4:    w = {1'b0, c.a | c.b};
      3'd5:    w = {1'b0, c.a};
      3'd6:    w = {1'b0, ~c.a};
      default: w = {1'b0, c.a} + {1'b0, c.b} + 5'd1;
    endcase
    r.r = w[3:0];
    r.c = w[4];
    r.z = (w[3:0] == 4'd0);
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) {bus.alu_result, bus.alu_carry, bus.alu_zero} <= '0;
    else       {bus.alu_result, bus.alu_carry, bus.alu_zero} <= alu_fn({bus.alu_opcode, bus.alu_op1, bus.alu_op2});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Transaction model: queued commands, the command in flight, edges until its result lands.
  cmd_t       m_fifo[$];
  cmd_t       m_cur      = '0;
  res_t       m_out      = '0;
  logic [2:0] m_out_op   = '0;
  int         m_wait     = -1;
  bit         m_present  = 1'b0;
  bit         m_push_last = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_fifo.delete();
      m_cur       = '0;
      m_out       = '0;
      m_out_op    = '0;
      m_wait      = -1;
      m_present   = 1'b0;
      m_push_last = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && (m_fifo.size() < DEPTH);
      do_pop  = (m_wait < 0) && !m_present && (m_fifo.size() > 0);
      if (m_present && bus.out_ready) m_present = 1'b0;
      if (m_wait == 0) begin
        m_out     = alu_fn(m_cur);
        m_out_op  = m_cur.op;
        m_present = 1'b1;
        m_wait    = -1;
      end else if (m_wait > 0) begin
        m_wait--;
      end
      if (do_pop) begin
        m_cur  = m_fifo.pop_front();
        m_wait = 1;
      end
      if (do_push) m_fifo.push_back({bus.in_opcode, bus.in_op1, bus.in_op2});
      m_push_last = do_push;
    end
  end

  res_t log_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready",   32'(bus.in_ready),   32'(m_fifo.size() < DEPTH));
      chk("count",      32'(bus.count),      32'(m_fifo.size()));
      chk("busy",       32'(bus.busy),       32'((m_wait >= 0) || m_present));
      chk("out_valid",  32'(bus.out_valid),  32'(m_present));
      chk("out_result", 32'(bus.out_result), 32'(m_out.r));
      chk("out_carry",  32'(bus.out_carry),  32'(m_out.c));
      chk("out_zero",   32'(bus.out_zero),   32'(m_out.z));
      chk("out_opcode", 32'(bus.out_opcode), 32'(m_out_op));
      chk("alu_drive",  32'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 32'(m_cur));
      if (bus.out_valid && bus.out_ready) log_q.push_back({bus.out_result, bus.out_carry, bus.out_zero});
    end
  end

  task automatic set_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.in_opcode = op;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!m_push_last && t < 64);
    if (!m_push_last) timeout("push_accept");
    bus.in_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    set_cmd(op, a, b);
    wait_accept();
  endtask

  task automatic wait_idle(input int max);
    int t = 0;
    while ((m_fifo.size() != 0 || m_wait >= 0 || m_present) && t < max) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (m_fifo.size() != 0 || m_wait >= 0 || m_present) timeout("drain");
  endtask

  initial begin
    int t;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Single ADD 10+10 offered as reset releases: 4-bit wrap gives 4 with carry.
    @(negedge clk);
    rstn = 1'b1;
    set_cmd(3'd0, 4'd10, 4'd10);
    @(posedge clk);
    #1;
    chk("first_push_count", 32'(bus.count), 32'd1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("latency_not_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("add_valid",  32'(bus.out_valid),  32'd1);
    chk("add_result", 32'(bus.out_result), 32'd4);
    chk("add_carry",  32'(bus.out_carry),  32'd1);
    chk("add_zero",   32'(bus.out_zero),   32'd0);
    chk("add_opcode", 32'(bus.out_opcode), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_idle(20);

    // Ordering: 1+1, 3-3, 5^5.
    log_q.delete();
    push(3'd0, 4'd1, 4'd1);
    push(3'd1, 4'd3, 4'd3);
    push(3'd2, 4'd5, 4'd5);
    t = 0;
    while (log_q.size() < 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (log_q.size() < 3) timeout("order_results");
    else begin
      chk("order0_result", 32'(log_q[0].r), 32'd2);
      chk("order0_zero",   32'(log_q[0].z), 32'd0);
      chk("order1_result", 32'(log_q[1].r), 32'd0);
      chk("order1_zero",   32'(log_q[1].z), 32'd1);
      chk("order2_result", 32'(log_q[2].r), 32'd0);
      chk("order2_zero",   32'(log_q[2].z), 32'd1);
    end
    wait_idle(40);

    // Fill with the consumer stalled, then a sixth command waits for a slot.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i), 4'(i), 4'(i + 1));
    chk("fill_count",    32'(bus.count),    32'd4);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    set_cmd(3'd7, 4'd15, 4'd15);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_count", 32'(bus.count),     32'd4);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    wait_accept();
    wait_idle(100);

    // Reset while a command is being captured with three more queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i + 2), 4'(3 * i), 4'(i));
    t = 0;
    while (!m_present && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!m_present) timeout("reset_setup");
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_count", 32'(bus.count),     32'd3);
    chk("pre_reset_busy",  32'(bus.busy),      32'd1);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd0);
    rstn = 1'b0;
    #1;
    chk("rst_count",     32'(bus.count),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
    chk("rst_busy",      32'(bus.busy),       32'd0);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_out_bus",   32'({bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode}), 32'd0);
    chk("rst_alu_drive", 32'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_valid_after_reset", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic in three load regimes: saturating, sparse, balanced.
    for (int phase = 0; phase < 3; phase++) begin
      for (int c = 0; c < 500; c++) begin
        @(posedge clk);
        #1;
        bus.in_opcode = 3'($urandom_range(0, 7));
        bus.in_op1    = 4'($urandom_range(0, 15));
        bus.in_op2    = 4'($urandom_range(0, 15));
        case (phase)
          0:       begin bus.in_valid = ($urandom_range(0, 3) != 0); bus.out_ready = ($urandom_range(0, 1) != 0); end
          1:       begin bus.in_valid = ($urandom_range(0, 3) == 0); bus.out_ready = 1'b1; end
          default: begin bus.in_valid = ($urandom_range(0, 1) != 0); bus.out_ready = ($urandom_range(0, 3) != 0); end
        endcase
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
